// File: rtl/t2mi_pkg.sv
// -----------------------------------------------------------------------------
// t2mi_pkg
// Shared constants and types for the T2-MI timestamp parsing slice.
//   SYNC_BYTE        : T2-MI packet header byte (0x47)
//   TS_TYPE_DEF      : default packet type that carries a timestamp
//   TS_LEN_DEF       : default payload length of a timestamp packet
//   MAX_LEN_DEF      : default largest accepted payload length
//   *_W              : timestamp field widths
//   parser_state_e   : parser FSM encoding (also exported on parser_state)
// -----------------------------------------------------------------------------
package t2mi_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'h47;
    localparam logic [7:0]  TS_TYPE_DEF  = 8'h20;
    localparam logic [15:0] TS_LEN_DEF   = 16'd12;
    localparam logic [15:0] MAX_LEN_DEF  = 16'd4096;

    localparam int BW_W  = 4;
    localparam int UTC_W = 16;
    localparam int SEC_W = 40;
    localparam int SUB_W = 32;

    localparam int TS_PAY_BYTES = 12;
    localparam int TS_SHADOW_W  = TS_PAY_BYTES * 8;

    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_TYPE   = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_LEN_LO = 3'd3,
        ST_TS_PAY = 3'd4,
        ST_SKIP   = 3'd5
    } parser_state_e;

endpackage

// File: rtl/t2mi_sync_lock.sv
// -----------------------------------------------------------------------------
// t2mi_sync_lock
// Framing-lock hysteresis. Counts consecutive good packets and consecutive
// framing errors; sync_locked rises once LOCK_THRESH good packets are seen in a
// row and falls once LOSS_THRESH errors are seen in a row.
// Ports:
//   clk_100mhz  : system clock
//   rst_n       : asynchronous active-low reset
//   good_pkt    : one-cycle strobe, a well-formed packet just completed
//   frame_err   : one-cycle strobe, a framing error was just detected
//   sync_locked : registered lock indication
// -----------------------------------------------------------------------------
module t2mi_sync_lock #(
    parameter int LOCK_THRESH = 3,
    parameter int LOSS_THRESH = 2
) (
    input  logic clk_100mhz,
    input  logic rst_n,
    input  logic good_pkt,
    input  logic frame_err,
    output logic sync_locked
);

    localparam logic [7:0] LOCK_T = 8'(LOCK_THRESH);
    localparam logic [7:0] LOSS_T = 8'(LOSS_THRESH);

    logic [7:0] good_cnt;
    logic [7:0] err_cnt;

    // The two strobes come from the same accepted byte and are mutually
    // exclusive; good_pkt is given priority only to keep the logic simple.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            good_cnt    <= '0;
            err_cnt     <= '0;
            sync_locked <= 1'b0;
        end else if (good_pkt) begin
            err_cnt <= '0;
            if (good_cnt < LOCK_T) begin
                good_cnt <= good_cnt + 8'd1;
            end
            if (good_cnt + 8'd1 >= LOCK_T) begin
                sync_locked <= 1'b1;
            end
        end else if (frame_err) begin
            good_cnt <= '0;
            if (err_cnt < LOSS_T) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (err_cnt + 8'd1 >= LOSS_T) begin
                sync_locked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/t2mi_timestamp_extractor.sv
// -----------------------------------------------------------------------------
// t2mi_timestamp_extractor
// Byte-level T2-MI parser. Frames packets on the 0x47 header byte, picks out
// timestamp packets and publishes bandwidth, UTC offset, seconds and
// subseconds with a one-cycle timestamp_valid strobe.
//
// Stream interface: in_valid qualifies in_data/in_sync; there is no ready, so
// every byte presented with in_valid=1 is consumed on that clock edge. Cycles
// with in_valid=0 are ignored entirely and may appear anywhere in a packet.
//
// Ports:
//   clk_100mhz, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_data, in_sync : input byte stream (in_sync marks byte 0)
//   ts_bw, ts_utc_offset,
//   ts_seconds, ts_subseconds  : last committed timestamp fields
//   timestamp_valid            : strobe, ts_* just updated
//   sync_locked                : framing lock
//   frame_error                : strobe per framing error
//   parser_state               : current FSM state (parser_state_e)
//   pkt_count, err_count       : saturating statistics
//
// Build option: define T2MI_TS_STATS_EN to implement pkt_count/err_count;
// otherwise both read as zero.
// -----------------------------------------------------------------------------
module t2mi_timestamp_extractor
    import t2mi_pkg::*;
#(
    parameter logic [7:0]  TS_TYPE     = TS_TYPE_DEF,
    parameter logic [15:0] TS_LEN      = TS_LEN_DEF,
    parameter logic [15:0] MAX_LEN     = MAX_LEN_DEF,
    parameter int          LOCK_THRESH = 3,
    parameter int          LOSS_THRESH = 2
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_sync,
    output logic [BW_W-1:0]   ts_bw,
    output logic [UTC_W-1:0]  ts_utc_offset,
    output logic [SEC_W-1:0]  ts_seconds,
    output logic [SUB_W-1:0]  ts_subseconds,
    output logic              timestamp_valid,
    output logic              sync_locked,
    output logic              frame_error,
    output logic [2:0]        parser_state,
    output logic [15:0]       pkt_count,
    output logic [15:0]       err_count
);

    localparam logic [3:0] LAST_IDX = 4'(TS_PAY_BYTES - 1);

    // Bit positions of the fields inside the 96-bit payload shadow
    // (byte 0 lands in the top byte after 12 shifts).
    localparam int SUB_LSB = 0;
    localparam int SEC_LSB = SUB_LSB + SUB_W;
    localparam int UTC_LSB = SEC_LSB + SEC_W;
    localparam int BW_LSB  = UTC_LSB + UTC_W;

    parser_state_e          state;
    logic [7:0]             pkt_type;
    logic [7:0]             len_hi;
    logic [15:0]            skip_cnt;
    logic [3:0]             pay_idx;
    logic [TS_SHADOW_W-1:0] shadow;
    logic [TS_SHADOW_W-1:0] shadow_next;
    logic [15:0]            len_now;
    logic                   good_now;
    logic                   err_now;
    logic                   ts_done;

    assign len_now      = {len_hi, in_data};
    assign shadow_next  = {shadow[TS_SHADOW_W-9:0], in_data};
    assign parser_state = state;

    // Per-byte outcome decode, shared by the FSM, the lock tracker and the
    // statistics counters so all of them see the same event on the same edge.
    always_comb begin
        good_now = 1'b0;
        err_now  = 1'b0;
        ts_done  = 1'b0;
        if (in_valid) begin
            if (in_sync) begin
                // Outside HUNT any sync is an abort; inside HUNT only a
                // sync on something other than the header byte is an error.
                if ((state != ST_HUNT) || (in_data != SYNC_BYTE)) begin
                    err_now = 1'b1;
                end
            end else begin
                case (state)
                    ST_LEN_LO: begin
                        if ((len_now > MAX_LEN) ||
                            ((pkt_type == TS_TYPE) && (len_now != TS_LEN))) begin
                            err_now = 1'b1;
                        end else if (len_now == 16'd0) begin
                            good_now = 1'b1;
                        end
                    end
                    ST_TS_PAY: begin
                        if (pay_idx == LAST_IDX) begin
                            good_now = 1'b1;
                            ts_done  = 1'b1;
                        end
                    end
                    ST_SKIP: begin
                        if (skip_cnt == 16'd1) begin
                            good_now = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_HUNT;
            pkt_type        <= '0;
            len_hi          <= '0;
            skip_cnt        <= '0;
            pay_idx         <= '0;
            shadow          <= '0;
            ts_bw           <= '0;
            ts_utc_offset   <= '0;
            ts_seconds      <= '0;
            ts_subseconds   <= '0;
            timestamp_valid <= 1'b0;
            frame_error     <= 1'b0;
        end else begin
            timestamp_valid <= 1'b0;
            frame_error     <= err_now;
            if (in_valid) begin
                if (in_sync && (state != ST_HUNT)) begin
                    // Abort; a header byte immediately restarts framing.
                    state <= (in_data == SYNC_BYTE) ? ST_TYPE : ST_HUNT;
                end else begin
                    case (state)
                        ST_HUNT: begin
                            if (in_sync && (in_data == SYNC_BYTE)) begin
                                state <= ST_TYPE;
                            end
                        end
                        ST_TYPE: begin
                            pkt_type <= in_data;
                            state    <= ST_LEN_HI;
                        end
                        ST_LEN_HI: begin
                            len_hi <= in_data;
                            state  <= ST_LEN_LO;
                        end
                        ST_LEN_LO: begin
                            if (err_now || good_now) begin
                                state <= ST_HUNT;
                            end else if (pkt_type == TS_TYPE) begin
                                pay_idx <= '0;
                                state   <= ST_TS_PAY;
                            end else begin
                                skip_cnt <= len_now;
                                state    <= ST_SKIP;
                            end
                        end
                        ST_TS_PAY: begin
                            shadow  <= shadow_next;
                            pay_idx <= pay_idx + 4'd1;
                            if (ts_done) begin
                                // Commit straight from the shifted value so the
                                // outputs update one cycle after the last byte.
                                ts_bw           <= shadow_next[BW_LSB  +: BW_W];
                                ts_utc_offset   <= shadow_next[UTC_LSB +: UTC_W];
                                ts_seconds      <= shadow_next[SEC_LSB +: SEC_W];
                                ts_subseconds   <= shadow_next[SUB_LSB +: SUB_W];
                                timestamp_valid <= 1'b1;
                                state           <= ST_HUNT;
                            end
                        end
                        ST_SKIP: begin
                            if (skip_cnt == 16'd1) begin
                                state <= ST_HUNT;
                            end else begin
                                skip_cnt <= skip_cnt - 16'd1;
                            end
                        end
                        default: state <= ST_HUNT;
                    endcase
                end
            end
        end
    end

    t2mi_sync_lock #(
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH)
    ) u_sync_lock (
        .clk_100mhz  (clk_100mhz),
        .rst_n       (rst_n),
        .good_pkt    (good_now),
        .frame_err   (err_now),
        .sync_locked (sync_locked)
    );

`ifdef T2MI_TS_STATS_EN
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            pkt_count <= '0;
            err_count <= '0;
        end else begin
            if (good_now && (pkt_count != 16'hFFFF)) begin
                pkt_count <= pkt_count + 16'd1;
            end
            if (err_now && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_t2mi_timestamp_extractor.sv
// -----------------------------------------------------------------------------
// tb_t2mi_timestamp_extractor
// Scenario tasks drive byte streams into t2mi_timestamp_extractor while a
// packet-level reference model (byte buffer per packet, no FSM) predicts the
// strobes, fields, lock and statistics cycle by cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_t2mi_timestamp_extractor;

    typedef logic [7:0] byte_q_t[$];

    logic        clk_100mhz = 1'b0;
    logic        rst_n      = 1'b0;
    logic        in_valid   = 1'b0;
    logic [7:0]  in_data    = 8'h00;
    logic        in_sync    = 1'b0;
    logic [3:0]  ts_bw;
    logic [15:0] ts_utc_offset;
    logic [39:0] ts_seconds;
    logic [31:0] ts_subseconds;
    logic        timestamp_valid;
    logic        sync_locked;
    logic        frame_error;
    logic [2:0]  parser_state;
    logic [15:0] pkt_count;
    logic [15:0] err_count;

    t2mi_timestamp_extractor dut (
        .clk_100mhz      (clk_100mhz),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_sync         (in_sync),
        .ts_bw           (ts_bw),
        .ts_utc_offset   (ts_utc_offset),
        .ts_seconds      (ts_seconds),
        .ts_subseconds   (ts_subseconds),
        .timestamp_valid (timestamp_valid),
        .sync_locked     (sync_locked),
        .frame_error     (frame_error),
        .parser_state    (parser_state),
        .pkt_count       (pkt_count),
        .err_count       (err_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_100mhz = ~clk_100mhz;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_buf[$];
    bit          m_in_pkt;
    int          m_good_run, m_err_run, m_pkts, m_errs;
    bit          m_locked, m_tv, m_fe;
    logic [3:0]  m_bw;
    logic [15:0] m_utc;
    logic [39:0] m_sec;
    logic [31:0] m_sub;

    // per-cycle tallies, cleared by each scenario
    int tv_seen, fe_seen, tv_bad, fe_bad, lock_bad, fld_bad, cnt_bad;

    task automatic model_reset();
        m_buf.delete();
        m_in_pkt = 0; m_good_run = 0; m_err_run = 0; m_locked = 0;
        m_pkts = 0; m_errs = 0; m_tv = 0; m_fe = 0;
        m_bw = '0; m_utc = '0; m_sec = '0; m_sub = '0;
    endtask

    task automatic clear_tallies();
        tv_seen = 0; fe_seen = 0; tv_bad = 0; fe_bad = 0;
        lock_bad = 0; fld_bad = 0; cnt_bad = 0;
    endtask

    // One accepted byte at packet level: buffer bytes since the header and
    // judge the packet from its type/length once four bytes are known.
    task automatic model_byte(input logic [7:0] d, input logic s);
        int         len;
        logic [7:0] typ;
        bit         good;
        good = 0; m_fe = 0; m_tv = 0;
        if (s) begin
            if (m_in_pkt || d != 8'h47) m_fe = 1;
            m_buf.delete();
            m_in_pkt = (d == 8'h47);
            if (m_in_pkt) m_buf.push_back(d);
        end else if (m_in_pkt) begin
            m_buf.push_back(d);
            if (m_buf.size() >= 4) begin
                typ = m_buf[1];
                len = {m_buf[2], m_buf[3]};
                if (m_buf.size() == 4 && (len > 4096 || (typ == 8'h20 && len != 12))) begin
                    m_fe = 1; m_in_pkt = 0;
                end else if (m_buf.size() == 4 + len) begin
                    good = 1; m_in_pkt = 0;
                    if (typ == 8'h20) begin
                        m_tv  = 1;
                        m_bw  = m_buf[4][3:0];
                        m_utc = {m_buf[5], m_buf[6]};
                        m_sec = {m_buf[7], m_buf[8], m_buf[9], m_buf[10], m_buf[11]};
                        m_sub = {m_buf[12], m_buf[13], m_buf[14], m_buf[15]};
                    end
                end
            end
        end
        if (good) begin
            m_err_run = 0; m_good_run++;
            if (m_good_run >= 3) m_locked = 1;
            if (m_pkts < 65535) m_pkts++;
        end
        if (m_fe) begin
            m_good_run = 0; m_err_run++;
            if (m_err_run >= 2) m_locked = 0;
            if (m_errs < 65535) m_errs++;
        end
    endtask

    task automatic sample();
        if (timestamp_valid === 1'b1) tv_seen++;
        if (frame_error === 1'b1) fe_seen++;
        if (timestamp_valid !== m_tv) tv_bad++;
        if (frame_error !== m_fe) fe_bad++;
        if (sync_locked !== m_locked) lock_bad++;
        if (ts_bw !== m_bw || ts_utc_offset !== m_utc ||
            ts_seconds !== m_sec || ts_subseconds !== m_sub) fld_bad++;
`ifdef T2MI_TS_STATS_EN
        if (pkt_count !== 16'(m_pkts) || err_count !== 16'(m_errs)) cnt_bad++;
`else
        if (pkt_count !== 16'd0 || err_count !== 16'd0) cnt_bad++;
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] d, input logic s);
        in_valid = 1'b1; in_data = d; in_sync = s;
        @(posedge clk_100mhz); #1;
        in_valid = 1'b0; in_sync = 1'b0; in_data = 8'($urandom);
        model_byte(d, s);
        sample();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100mhz); #1;
            m_tv = 0; m_fe = 0;
            sample();
        end
    endtask

    task automatic send_pkt(input byte_q_t p, input int gap_at, input int gap_len);
        for (int i = 0; i < p.size(); i++) begin
            if (i == gap_at) idle(gap_len);
            send_byte(p[i], (i == 0));
        end
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; in_sync = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_100mhz);
        @(negedge clk_100mhz); rst_n = 1'b1;
        @(posedge clk_100mhz); #1;
        model_reset();
    endtask

    function automatic byte_q_t ts_pkt(input logic [3:0] bw, input logic [15:0] utc,
                                       input logic [39:0] sec, input logic [31:0] sub);
        byte_q_t q;
        q.push_back(8'h47); q.push_back(8'h20); q.push_back(8'h00); q.push_back(8'h0C);
        q.push_back({4'h0, bw});
        q.push_back(utc[15:8]); q.push_back(utc[7:0]);
        q.push_back(sec[39:32]); q.push_back(sec[31:24]); q.push_back(sec[23:16]);
        q.push_back(sec[15:8]); q.push_back(sec[7:0]);
        q.push_back(sub[31:24]); q.push_back(sub[23:16]); q.push_back(sub[15:8]); q.push_back(sub[7:0]);
        return q;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        n_tests++; if (timestamp_valid !== 1'b0 || frame_error !== 1'b0 || sync_locked !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes tv=%b fe=%b lock=%b required 0/0/0", timestamp_valid, frame_error, sync_locked); end
        n_tests++; if ({ts_bw, ts_utc_offset, ts_seconds, ts_subseconds} !== 92'd0) begin
            n_fail++; $display("FAIL reset_fields got %h/%h/%h/%h required all 0", ts_bw, ts_utc_offset, ts_seconds, ts_subseconds); end
        n_tests++; if (parser_state !== 3'd0 || pkt_count !== 16'd0 || err_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_state state=%0d pkt=%0d err=%0d required 0", parser_state, pkt_count, err_count); end
    endtask

    task automatic test_basic();
        clear_tallies();
        send_pkt(ts_pkt(4'h5, 16'h0025, 40'h123456789A, 32'h80000000), -1, 0);
        n_tests++; if (timestamp_valid !== 1'b1) begin
            n_fail++; $display("FAIL basic_latency tv=%b one cycle after last byte, required 1", timestamp_valid); end
        idle(2);
        n_tests++; if (tv_seen !== 1 || tv_bad !== 0) begin
            n_fail++; $display("FAIL basic_strobe pulses=%0d bad_cycles=%0d required 1/0", tv_seen, tv_bad); end
        n_tests++; if (ts_bw !== 4'h5 || ts_utc_offset !== 16'h0025) begin
            n_fail++; $display("FAIL basic_bw_utc got %h/%h required 5/0025", ts_bw, ts_utc_offset); end
        n_tests++; if (ts_seconds !== 40'h123456789A || ts_subseconds !== 32'h80000000) begin
            n_fail++; $display("FAIL basic_time got %h/%h required 123456789a/80000000", ts_seconds, ts_subseconds); end
        n_tests++; if (fe_seen !== 0 || fld_bad !== 0 || cnt_bad !== 0) begin
            n_fail++; $display("FAIL basic_model fe=%0d fld_bad=%0d cnt_bad=%0d required 0", fe_seen, fld_bad, cnt_bad); end
    endtask

    task automatic test_gap();
        clear_tallies();
        send_pkt(ts_pkt(4'h5, 16'h0025, 40'h123456789A, 32'h80000000), 8, 3);
        n_tests++; if (timestamp_valid !== 1'b1) begin
            n_fail++; $display("FAIL gap_latency tv=%b required 1", timestamp_valid); end
        idle(1);
        n_tests++; if (tv_seen !== 1 || tv_bad !== 0 || fld_bad !== 0) begin
            n_fail++; $display("FAIL gap_strobe pulses=%0d bad=%0d fld_bad=%0d required 1/0/0", tv_seen, tv_bad, fld_bad); end
        n_tests++; if (ts_seconds !== 40'h123456789A || ts_subseconds !== 32'h80000000) begin
            n_fail++; $display("FAIL gap_fields got %h/%h required 123456789a/80000000", ts_seconds, ts_subseconds); end
    endtask

    task automatic test_skip_then_ts();
        byte_q_t p;
        apply_reset();
        clear_tallies();
        p.push_back(8'h47); p.push_back(8'h10); p.push_back(8'h00); p.push_back(8'h04);
        p.push_back(8'h47); p.push_back(8'h20); p.push_back(8'h00); p.push_back(8'h0C);
        send_pkt(p, -1, 0);
        idle(1);
        n_tests++; if (tv_seen !== 0 || parser_state !== 3'd0) begin
            n_fail++; $display("FAIL skip_no_strobe pulses=%0d state=%0d required 0/0", tv_seen, parser_state); end
        send_pkt(ts_pkt(4'h5, 16'h0025, 40'h123456789B, 32'h0), -1, 0);
        idle(1);
        n_tests++; if (tv_seen !== 1 || ts_seconds !== 40'h123456789B || ts_subseconds !== 32'h0) begin
            n_fail++; $display("FAIL skip_second pulses=%0d sec=%h sub=%h required 1/123456789b/0", tv_seen, ts_seconds, ts_subseconds); end
`ifdef T2MI_TS_STATS_EN
        n_tests++; if (pkt_count !== 16'd2) begin
            n_fail++; $display("FAIL skip_pkt_count got=%0d required 2", pkt_count); end
`else
        n_tests++; if (pkt_count !== 16'd0) begin
            n_fail++; $display("FAIL skip_pkt_count got=%0d required 0", pkt_count); end
`endif
        n_tests++; if (tv_bad !== 0 || fe_bad !== 0 || fld_bad !== 0 || cnt_bad !== 0) begin
            n_fail++; $display("FAIL skip_model tv=%0d fe=%0d fld=%0d cnt=%0d required 0", tv_bad, fe_bad, fld_bad, cnt_bad); end
    endtask

    task automatic test_lock_loss();
        byte_q_t p;
        apply_reset();
        clear_tallies();
        p = ts_pkt(4'h5, 16'h0025, 40'h123456789A, 32'h80000000);
        send_pkt(p, -1, 0);
        send_pkt(p, 2, 1);
        n_tests++; if (sync_locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_early got=%b after 2 packets required 0", sync_locked); end
        send_pkt(p, -1, 0);
        n_tests++; if (sync_locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_rise got=%b after 3 packets required 1", sync_locked); end
        for (int i = 0; i < 7; i++) send_byte(p[i], (i == 0));
        for (int i = 0; i < 8; i++) send_byte(p[i], (i == 0));
        n_tests++; if (sync_locked !== 1'b1) begin
            n_fail++; $display("FAIL lock_one_err got=%b after 1 abort required 1", sync_locked); end
        send_byte(8'h00, 1'b1);
        idle(1);
        n_tests++; if (fe_seen !== 2 || sync_locked !== 1'b0) begin
            n_fail++; $display("FAIL lock_loss fe=%0d lock=%b required 2/0", fe_seen, sync_locked); end
        n_tests++; if (tv_seen !== 3 || ts_seconds !== 40'h123456789A || ts_utc_offset !== 16'h0025) begin
            n_fail++; $display("FAIL lock_ts_hold pulses=%0d sec=%h utc=%h required 3/123456789a/0025", tv_seen, ts_seconds, ts_utc_offset); end
        n_tests++; if (lock_bad !== 0 || fe_bad !== 0 || tv_bad !== 0 || cnt_bad !== 0) begin
            n_fail++; $display("FAIL lock_model lock=%0d fe=%0d tv=%0d cnt=%0d required 0", lock_bad, fe_bad, tv_bad, cnt_bad); end
    endtask

    task automatic test_bad_len();
        byte_q_t p;
        clear_tallies();
        p.push_back(8'h47); p.push_back(8'h20); p.push_back(8'h00); p.push_back(8'h0D);
        send_pkt(p, -1, 0);
        n_tests++; if (frame_error !== 1'b1 || parser_state !== 3'd0) begin
            n_fail++; $display("FAIL badlen_err fe=%b state=%0d required 1/0", frame_error, parser_state); end
        send_pkt(ts_pkt(4'hA, 16'h0012, 40'h0000000001, 32'h40000000), -1, 0);
        idle(1);
        n_tests++; if (tv_seen !== 1 || ts_bw !== 4'hA || ts_seconds !== 40'h1 || ts_subseconds !== 32'h40000000) begin
            n_fail++; $display("FAIL badlen_next pulses=%0d bw=%h sec=%h sub=%h required 1/a/1/40000000", tv_seen, ts_bw, ts_seconds, ts_subseconds); end
        n_tests++; if (fe_seen !== 1 || fld_bad !== 0 || lock_bad !== 0) begin
            n_fail++; $display("FAIL badlen_model fe=%0d fld=%0d lock=%0d required 1/0/0", fe_seen, fld_bad, lock_bad); end
    endtask

    task automatic test_reset_mid();
        byte_q_t p;
        clear_tallies();
        p = ts_pkt(4'h3, 16'h0102, 40'h0A0B0C0D0E, 32'h11223344);
        for (int i = 0; i < 10; i++) send_byte(p[i], (i == 0));
        in_valid = 1'b1; in_data = p[10]; in_sync = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({ts_bw, ts_utc_offset, ts_seconds, ts_subseconds} !== 92'd0 || parser_state !== 3'd0) begin
            n_fail++; $display("FAIL rstmid_fields got %h/%h/%h/%h state=%0d required 0", ts_bw, ts_utc_offset, ts_seconds, ts_subseconds, parser_state); end
        n_tests++; if (timestamp_valid !== 1'b0 || frame_error !== 1'b0 || sync_locked !== 1'b0 || pkt_count !== 16'd0) begin
            n_fail++; $display("FAIL rstmid_flags tv=%b fe=%b lock=%b pkt=%0d required 0", timestamp_valid, frame_error, sync_locked, pkt_count); end
        in_valid = 1'b0;
        @(posedge clk_100mhz);
        @(negedge clk_100mhz); rst_n = 1'b1;
        @(posedge clk_100mhz); #1;
        model_reset();
        clear_tallies();
        send_pkt(p, -1, 0);
        idle(1);
        n_tests++; if (tv_seen !== 1 || ts_bw !== 4'h3 || ts_utc_offset !== 16'h0102 ||
                       ts_seconds !== 40'h0A0B0C0D0E || ts_subseconds !== 32'h11223344) begin
            n_fail++; $display("FAIL rstmid_next pulses=%0d got %h/%h/%h/%h required 1/3/0102/0a0b0c0d0e/11223344",
                               tv_seen, ts_bw, ts_utc_offset, ts_seconds, ts_subseconds); end
    endtask

    task automatic test_random();
        clear_tallies();
        for (int n = 0; n < 60; n++) begin
            byte_q_t p;
            int kind, len, cut;
            logic [7:0] typ;
            kind = $urandom_range(0, 9);
            typ  = (kind < 5) ? 8'h20 : 8'($urandom_range(0, 255));
            if (typ == 8'h20) len = (kind == 0) ? $urandom_range(13, 20) : 12;
            else              len = (kind == 9) ? 5000 : $urandom_range(0, 20);
            p.push_back(8'h47); p.push_back(typ); p.push_back(8'(len >> 8)); p.push_back(8'(len));
            if (len <= 4096 && !(typ == 8'h20 && len != 12))
                for (int i = 0; i < len; i++) p.push_back(8'($urandom));
            cut = ($urandom_range(0, 7) == 0) ? $urandom_range(1, p.size()) : p.size();
            for (int i = 0; i < cut; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                send_byte(p[i], (i == 0));
            end
            if ($urandom_range(0, 9) == 0) send_byte(8'($urandom_range(0, 70)), 1'b1);
            if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), 1'b0);
        end
        idle(2);
        n_tests++; if (tv_bad !== 0 || fe_bad !== 0) begin
            n_fail++; $display("FAIL random_strobes tv_bad=%0d fe_bad=%0d required 0/0", tv_bad, fe_bad); end
        n_tests++; if (fld_bad !== 0 || lock_bad !== 0 || cnt_bad !== 0) begin
            n_fail++; $display("FAIL random_state fld_bad=%0d lock_bad=%0d cnt_bad=%0d required 0", fld_bad, lock_bad, cnt_bad); end
    endtask

    initial begin
        model_reset();
        clear_tallies();
        test_reset();
        test_basic();
        test_gap();
        test_skip_then_ts();
        test_lock_loss();
        test_bad_len();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
